clap_light_controller: RTL and testbench

- Consumer end of the clap-count valid/ready stream produced by the clap detector.
- Decodes each clap-count word into a light command: toggle on/off, step brightness, or force off.
- Drives a PWM-dimmed LED bank on the DE0-Nano.
- Applies a post-command holdoff so that echoes and rapid re-detections are not acted upon.

---
 rtl/clap_light_pkg.sv | 28 ++
 rtl/clap_light_pwm.sv | 38 +++
 rtl/clap_light_controller.sv | 130 +++++++++++++
 tb/tb_clap_light_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/clap_light_pkg.sv
// Shared definitions for the clap light controller: FSM encoding, default
// clap-count commands and the width helper used for the brightness index.
package clap_light_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  localparam int DEFAULT_TOGGLE_CLAPS = 2;
  localparam int DEFAULT_CYCLE_CLAPS  = 3;
  localparam int DEFAULT_OFF_CLAPS    = 4;

  // Number of bits needed to represent value (value >= 1).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/clap_light_pwm.sv
// Free-running PWM generator: converts a brightness level and on/off state
// into a registered, identical drive for every LED.
module clap_light_pwm
  import clap_light_pkg::*;
#(
  parameter int PWM_WIDTH         = 8,
  parameter int BRIGHTNESS_LEVELS = 4,
  parameter int LED_COUNT         = 8
) (
  input  logic                                   clock,
  input  logic                                   counters_nreset,
  input  logic [clogb2(BRIGHTNESS_LEVELS-1)-1:0] level_i,
  input  logic                                   light_on_i,
  output logic [LED_COUNT-1:0]                   leds_o
);

  logic [PWM_WIDTH-1:0] pwm_cnt_q;
  logic [PWM_WIDTH:0]   duty;
  logic [LED_COUNT-1:0] leds_q;

  // One extra bit lets the top level reach 2^PWM_WIDTH, i.e. always on.
  always_comb begin
    duty = (PWM_WIDTH+1)'(((32'(level_i) + 32'd1) << PWM_WIDTH) / 32'(BRIGHTNESS_LEVELS));
  end

  always_ff @(posedge clock or negedge counters_nreset) begin
    if (!counters_nreset) begin
      pwm_cnt_q <= '0;
      leds_q    <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_WIDTH'(1);
      leds_q    <= {LED_COUNT{light_on_i && ({1'b0, pwm_cnt_q} < duty)}};
    end
  end

  assign leds_o = leds_q;

endmodule

// File: rtl/clap_light_controller.sv
// Consumes clap-count words over valid/ready, decodes them into light commands
// and ignores further words for a holdoff window after each command.
module clap_light_controller
  import clap_light_pkg::*;
#(
  parameter int CLAPS_IN_WIDTH    = 16,
  parameter int LED_COUNT         = 8,
  parameter int PWM_WIDTH         = 8,
  parameter int BRIGHTNESS_LEVELS = 4,
  parameter int TOGGLE_CLAPS      = DEFAULT_TOGGLE_CLAPS,
  parameter int CYCLE_CLAPS       = DEFAULT_CYCLE_CLAPS,
  parameter int OFF_CLAPS         = DEFAULT_OFF_CLAPS,
  parameter int HOLDOFF_CYCLES    = 50000000
) (
  input  logic                                   clock,
  input  logic                                   counters_nreset,
  input  logic [CLAPS_IN_WIDTH-1:0]              claps_in_data,
  input  logic                                   claps_in_valid,
  output logic                                   claps_in_ready,
  output logic [LED_COUNT-1:0]                   leds,
  output logic                                   light_on,
  output logic [clogb2(BRIGHTNESS_LEVELS-1)-1:0] brightness_level,
  output logic                                   command_pulse
);

  localparam int LVL_W = clogb2(BRIGHTNESS_LEVELS-1);
  localparam int HC_W  = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

  localparam logic [LVL_W-1:0]          LVL_MAX = LVL_W'(BRIGHTNESS_LEVELS - 1);
  localparam logic [HC_W-1:0]           HC_LAST = HC_W'(HOLDOFF_CYCLES);
  localparam logic [CLAPS_IN_WIDTH-1:0] OFF_C   = CLAPS_IN_WIDTH'(OFF_CLAPS);
  localparam logic [CLAPS_IN_WIDTH-1:0] CYCLE_C = CLAPS_IN_WIDTH'(CYCLE_CLAPS);
  localparam logic [CLAPS_IN_WIDTH-1:0] TOGGLE_C = CLAPS_IN_WIDTH'(TOGGLE_CLAPS);

  state_t                    state_q;
  logic [CLAPS_IN_WIDTH-1:0] data_q;
  logic [HC_W-1:0]           hold_cnt_q;
  logic                      ready_q;
  logic                      light_on_q;
  logic [LVL_W-1:0]          level_q;
  logic                      pulse_q;

  logic is_off;
  logic is_cycle;
  logic is_toggle;

  assign is_off    = (data_q >= OFF_C);
  assign is_cycle  = (data_q == CYCLE_C);
  assign is_toggle = (data_q == TOGGLE_C);

  // HOLDOFF lasts HOLDOFF_CYCLES+1 clocks so ready returns at N+2+HOLDOFF_CYCLES.
  always_ff @(posedge clock or negedge counters_nreset) begin
    if (!counters_nreset) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      hold_cnt_q <= '0;
      ready_q    <= 1'b0;
      light_on_q <= 1'b0;
      level_q    <= LVL_MAX;
      pulse_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch reads pre-edge state.
      pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (claps_in_valid && ready_q) begin
            data_q  <= claps_in_data;
            ready_q <= 1'b0;
            state_q <= ST_DECODE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (is_off) begin
            light_on_q <= 1'b0;
            level_q    <= LVL_MAX;
          end else if (is_cycle) begin
            if (light_on_q) begin
              level_q <= (level_q == LVL_MAX) ? '0 : level_q + LVL_W'(1);
            end else begin
              light_on_q <= 1'b1;
              level_q    <= '0;
            end
          end else if (is_toggle) begin
            light_on_q <= ~light_on_q;
          end
          if (is_off || is_cycle || is_toggle) begin
            pulse_q    <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= ST_HOLDOFF;
          end else begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt_q == HC_LAST) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + HC_W'(1);
          end
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign claps_in_ready   = ready_q;
  assign light_on         = light_on_q;
  assign brightness_level = level_q;
  assign command_pulse    = pulse_q;

  clap_light_pwm #(
    .PWM_WIDTH        (PWM_WIDTH),
    .BRIGHTNESS_LEVELS(BRIGHTNESS_LEVELS),
    .LED_COUNT        (LED_COUNT)
  ) u_pwm (
    .clock          (clock),
    .counters_nreset(counters_nreset),
    .level_i        (level_q),
    .light_on_i     (light_on_q),
    .leds_o         (leds)
  );

endmodule

// File: tb/tb_clap_light_controller.sv
// Directed bench for clap_light_controller: a command table for the decode,
// level stepping and PWM duty, plus hand sequences for holdoff and reset.
module tb_clap_light_controller;

  localparam int CW = 16;
  localparam int HOLD = 8;

  logic          clock;
  logic          counters_nreset;
  logic [CW-1:0] claps_in_data;
  logic          claps_in_valid;
  logic          claps_in_ready;
  logic [7:0]    leds;
  logic          light_on;
  logic [1:0]    brightness_level;
  logic          command_pulse;

  int checks = 0;
  int failures = 0;

  clap_light_controller #(
    .CLAPS_IN_WIDTH   (CW),
    .LED_COUNT        (8),
    .PWM_WIDTH        (4),
    .BRIGHTNESS_LEVELS(4),
    .TOGGLE_CLAPS     (2),
    .CYCLE_CLAPS      (3),
    .OFF_CLAPS        (4),
    .HOLDOFF_CYCLES   (HOLD)
  ) dut (
    .clock           (clock),
    .counters_nreset (counters_nreset),
    .claps_in_data   (claps_in_data),
    .claps_in_valid  (claps_in_valid),
    .claps_in_ready  (claps_in_ready),
    .leds            (leds),
    .light_on        (light_on),
    .brightness_level(brightness_level),
    .command_pulse   (command_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [CW-1:0] claps;
    logic          exp_on;
    logic [1:0]    exp_lvl;
    logic          exp_pulse;
    int            exp_wait;
    int            exp_high;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits for ready, transfers one word, and returns at the negedge after the
  // decode edge (light_on/level/pulse already updated there).
  task automatic issue(input logic [CW-1:0] c);
    int n;
    n = 0;
    while (!claps_in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("ready_before_send", 32'(claps_in_ready), 32'd1);
    claps_in_valid = 1'b1;
    claps_in_data  = c;
    @(negedge clock);
    claps_in_valid = 1'b0;
    check("ready_low_in_decode", 32'(claps_in_ready), 32'd0);
    @(negedge clock);
  endtask

  task automatic wait_ready(output int k);
    k = 0;
    while (!claps_in_ready && k < 200) begin
      @(negedge clock);
      k++;
    end
  endtask

  // Counts cycles with all LEDs on over one 16-clock PWM period.
  task automatic measure_duty(output int high, output int bad);
    high = 0;
    bad  = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      if (leds == 8'hFF) high++;
      else if (leds != 8'h00) bad++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int high;
    int bad;
    int seen;

    vecs[0]  = '{16'd2,      1'b1, 2'd3, 1'b1, HOLD+1, 16};
    vecs[1]  = '{16'd3,      1'b1, 2'd0, 1'b1, HOLD+1, 4};
    vecs[2]  = '{16'd3,      1'b1, 2'd1, 1'b1, HOLD+1, 8};
    vecs[3]  = '{16'd3,      1'b1, 2'd2, 1'b1, HOLD+1, 12};
    vecs[4]  = '{16'd3,      1'b1, 2'd3, 1'b1, HOLD+1, 16};
    vecs[5]  = '{16'd1,      1'b1, 2'd3, 1'b0, 0,      16};
    vecs[6]  = '{16'd0,      1'b1, 2'd3, 1'b0, 0,      16};
    vecs[7]  = '{16'd3,      1'b1, 2'd0, 1'b1, HOLD+1, 4};
    vecs[8]  = '{16'd3,      1'b1, 2'd1, 1'b1, HOLD+1, 8};
    vecs[9]  = '{16'd2,      1'b0, 2'd1, 1'b1, HOLD+1, 0};
    vecs[10] = '{16'd2,      1'b1, 2'd1, 1'b1, HOLD+1, 8};
    vecs[11] = '{16'h0102,   1'b0, 2'd3, 1'b1, HOLD+1, 0};
    vecs[12] = '{16'd3,      1'b1, 2'd0, 1'b1, HOLD+1, 4};
    vecs[13] = '{16'd4,      1'b0, 2'd3, 1'b1, HOLD+1, 0};
    vecs[14] = '{16'hFFFF,   1'b0, 2'd3, 1'b1, HOLD+1, 0};
    vecs[15] = '{16'd3,      1'b1, 2'd0, 1'b1, HOLD+1, 4};
    vecs[16] = '{16'd3,      1'b1, 2'd1, 1'b1, HOLD+1, 8};

    // Reset state, then idle with no input.
    counters_nreset = 1'b0;
    claps_in_valid  = 1'b0;
    claps_in_data   = '0;
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(claps_in_ready), 32'd0);
    check("rst_light", 32'(light_on), 32'd0);
    check("rst_level", 32'(brightness_level), 32'd3);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_pulse", 32'(command_pulse), 32'd0);
    counters_nreset = 1'b1;
    @(negedge clock);
    check("ready_after_release", 32'(claps_in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (leds != 8'h00 || light_on || command_pulse) seen++;
    end
    check("idle_leds_dark_64", 32'(seen), 32'd0);
    check("idle_level", 32'(brightness_level), 32'd3);

    // Command table.
    for (int v = 0; v < 17; v++) begin
      issue(vecs[v].claps);
      check($sformatf("v%0d_light", v), 32'(light_on), 32'(vecs[v].exp_on));
      check($sformatf("v%0d_level", v), 32'(brightness_level), 32'(vecs[v].exp_lvl));
      check($sformatf("v%0d_pulse", v), 32'(command_pulse), 32'(vecs[v].exp_pulse));
      wait_ready(k);
      check($sformatf("v%0d_ready_wait", v), 32'(k), 32'(vecs[v].exp_wait));
      @(negedge clock);
      check($sformatf("v%0d_pulse_dropped", v), 32'(command_pulse), 32'd0);
      measure_duty(high, bad);
      check($sformatf("v%0d_duty", v), 32'(high), 32'(vecs[v].exp_high));
      check($sformatf("v%0d_leds_uniform", v), 32'(bad), 32'd0);
    end

    // Force off from level 1, with a toggle word held valid through holdoff.
    while (!claps_in_ready) @(negedge clock);
    claps_in_valid = 1'b1;
    claps_in_data  = 16'd7;
    @(negedge clock);
    claps_in_data  = 16'd2;
    @(negedge clock);
    check("off7_light", 32'(light_on), 32'd0);
    check("off7_level", 32'(brightness_level), 32'd3);
    check("off7_pulse", 32'(command_pulse), 32'd1);
    k = 0;
    seen = 0;
    while (!claps_in_ready && k < 200) begin
      @(negedge clock);
      k++;
      if (light_on) seen++;
    end
    check("off7_ready_wait", 32'(k), 32'(HOLD+1));
    check("held_word_not_taken", 32'(seen), 32'd0);
    check("off7_leds", 32'(leds), 32'd0);
    @(negedge clock);
    check("held_word_taken", 32'(claps_in_ready), 32'd0);
    claps_in_valid = 1'b0;
    @(negedge clock);
    check("held_toggle_light", 32'(light_on), 32'd1);
    check("held_toggle_level", 32'(brightness_level), 32'd3);
    check("held_toggle_pulse", 32'(command_pulse), 32'd1);
    wait_ready(k);
    check("held_toggle_wait", 32'(k), 32'(HOLD+1));

    // Asynchronous reset in the middle of holdoff.
    issue(16'd3);
    check("pre_rst_level", 32'(brightness_level), 32'd0);
    repeat (2) @(negedge clock);
    #2;
    counters_nreset = 1'b0;
    #1;
    check("async_rst_light", 32'(light_on), 32'd0);
    check("async_rst_level", 32'(brightness_level), 32'd3);
    check("async_rst_ready", 32'(claps_in_ready), 32'd0);
    check("async_rst_leds", 32'(leds), 32'd0);
    check("async_rst_pulse", 32'(command_pulse), 32'd0);
    repeat (2) @(negedge clock);
    counters_nreset = 1'b1;
    @(negedge clock);
    check("post_rst_ready", 32'(claps_in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (light_on || command_pulse || leds != 8'h00 || !claps_in_ready) seen++;
    end
    check("post_rst_quiet", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
